// File: rtl/mux_4x1_arbiter.sv
// Round-robin owner of a shared 4:1 mux: grant/cells/valid 1 cycle after req, result 1 cycle after grant.
// No backpressure; optional MUX_ARB_TIMEOUT_EN rotates an owner that holds the grant for MAX_HOLD cycles while others wait.
module mux_4x1_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] inputs,
  output logic [1:0] cells,
  output logic [3:0] grant,
  output logic       valid,
  output logic       result
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state;
  logic [1:0] last;
  logic [3:0] others;
  logic       owner_req;
  logic [1:0] win_idle;
  logic [1:0] win_busy;

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("mux_4x1_arbiter: MAX_HOLD must be within 2..255");
  end

  // First set bit strictly after 'after', wrapping; 'after' itself is checked last.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] after);
    logic [1:0] idx;
    logic [1:0] pick;
    pick = after;
    for (int k = 4; k >= 1; k--) begin
      idx = after + 2'(k);
      if (r[idx]) pick = idx;
    end
    return pick;
  endfunction

  always_comb begin
    owner_req = req[cells];
    others    = req & ~(4'b0001 << cells);
    win_idle  = rr_pick(req, last);
    win_busy  = rr_pick(others, cells);
  end

`ifdef MUX_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] hold_cnt;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      last   <= 2'd3;
      cells  <= 2'b00;
      grant  <= 4'b0000;
      valid  <= 1'b0;
      result <= 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
      hold_cnt <= 8'd0;
`endif
    end else begin
      result <= valid ? inputs[cells] : 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            state <= BUSY;
            cells <= win_idle;
            last  <= win_idle;
            grant <= 4'b0001 << win_idle;
            valid <= 1'b1;
`ifdef MUX_ARB_TIMEOUT_EN
            hold_cnt <= 8'd0;
`endif
          end
        end
        BUSY: begin
          if (!owner_req) begin
            if (|others) begin
              cells <= win_busy;
              last  <= win_busy;
              grant <= 4'b0001 << win_busy;
`ifdef MUX_ARB_TIMEOUT_EN
              hold_cnt <= 8'd0;
`endif
            end else begin
              // cells keeps the last owner so the next search rotates from it
              state <= IDLE;
              grant <= 4'b0000;
              valid <= 1'b0;
            end
          end
`ifdef MUX_ARB_TIMEOUT_EN
          else if (hold_cnt == HOLD_LAST) begin
            if (|others) begin
              cells    <= win_busy;
              last     <= win_busy;
              grant    <= 4'b0001 << win_busy;
              hold_cnt <= 8'd0;
            end
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_4x1_arbiter.sv
// Directed bench for mux_4x1_arbiter with a queue of expected outputs per driven cycle.
module tb_mux_4x1_arbiter;

  typedef struct {
    logic [3:0] grant;
    logic [1:0] cells;
    logic       valid;
    logic       result;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] inputs = 4'b0000;
  logic [1:0] cells;
  logic [3:0] grant;
  logic       valid;
  logic       result;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  mux_4x1_arbiter #(.MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst), .req(req), .inputs(inputs),
    .cells(cells), .grant(grant), .valid(valid), .result(result)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue what the outputs must be after the edge, then compare.
  task automatic cyc(input string tag, input logic [3:0] r, input logic [3:0] in,
                     input logic [3:0] eg, input logic [1:0] ec, input logic ev, input logic er);
    exp_t e;
    req    = r;
    inputs = in;
    sb.push_back('{grant: eg, cells: ec, valid: ev, result: er});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, ".grant"},  grant,          e.grant);
    chk({tag, ".cells"},  {2'b00, cells}, {2'b00, e.cells});
    chk({tag, ".valid"},  {3'b000, valid},  {3'b000, e.valid});
    chk({tag, ".result"}, {3'b000, result}, {3'b000, e.result});
  endtask

  initial begin
    // reset state
    #2;
    chk("rst.grant", grant, 4'b0000);
    chk("rst.cells", {2'b00, cells}, 4'b0000);
    chk("rst.valid", {3'b000, valid}, 4'b0000);
    chk("rst.result", {3'b000, result}, 4'b0000);
    @(posedge clk); #1;
    rst = 1'b0;

    // two requesters, then direct handover with no bubble
    cyc("t1a", 4'b0101, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0);
    cyc("t1b", 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0);
    cyc("t1c", 4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0);

    // single requester, data path and gating after release
    cyc("t2a", 4'b0010, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0);
    cyc("t2b", 4'b0010, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b1);
    cyc("t2c", 4'b0000, 4'b0010, 4'b0000, 2'd1, 1'b0, 1'b1);
    cyc("t2d", 4'b0000, 4'b0010, 4'b0000, 2'd1, 1'b0, 1'b0);

    // fairness from a fresh reset: 0,1,2,3,0 with two granted cycles each
    rst = 1'b1;
    #2;
    chk("t3.rst.cells", {2'b00, cells}, 4'b0000);
    rst = 1'b0;
    cyc("t3c1", 4'b1111, 4'b1010, 4'b0001, 2'd0, 1'b1, 1'b0);
    cyc("t3c2", 4'b1111, 4'b1010, 4'b0001, 2'd0, 1'b1, 1'b0);
    cyc("t3c3", 4'b1110, 4'b1010, 4'b0010, 2'd1, 1'b1, 1'b0);
    cyc("t3c4", 4'b1111, 4'b1010, 4'b0010, 2'd1, 1'b1, 1'b1);
    cyc("t3c5", 4'b1101, 4'b1010, 4'b0100, 2'd2, 1'b1, 1'b1);
    cyc("t3c6", 4'b1111, 4'b1010, 4'b0100, 2'd2, 1'b1, 1'b0);
    cyc("t3c7", 4'b1011, 4'b1010, 4'b1000, 2'd3, 1'b1, 1'b0);
    cyc("t3c8", 4'b1111, 4'b1010, 4'b1000, 2'd3, 1'b1, 1'b1);
    cyc("t3c9", 4'b0111, 4'b1010, 4'b0001, 2'd0, 1'b1, 1'b1);
    cyc("t3end", 4'b0000, 4'b1010, 4'b0000, 2'd0, 1'b0, 1'b0);

    // asynchronous reset while owner 2 is busy
    cyc("t4a", 4'b0100, 4'b1111, 4'b0100, 2'd2, 1'b1, 1'b0);
    cyc("t4b", 4'b0100, 4'b1111, 4'b0100, 2'd2, 1'b1, 1'b1);
    rst = 1'b1;
    #1;
    chk("t4.async.grant", grant, 4'b0000);
    chk("t4.async.cells", {2'b00, cells}, 4'b0000);
    chk("t4.async.valid", {3'b000, valid}, 4'b0000);
    chk("t4.async.result", {3'b000, result}, 4'b0000);
    @(posedge clk); #1;
    rst = 1'b0;
    cyc("t4c", 4'b1100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0);

    // long hold with two requesters: handover from owner 2 lands on 0
`ifdef MUX_ARB_TIMEOUT_EN
    for (int i = 0; i < 12; i++) begin
      if ((i / 4) % 2 == 0)
        cyc($sformatf("t5to%0d", i), 4'b0011, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0);
      else
        cyc($sformatf("t5to%0d", i), 4'b0011, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0);
    end
`else
    for (int i = 0; i < 52; i++)
      cyc($sformatf("t5hold%0d", i), 4'b0011, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0);
`endif

    // sole requester keeps the grant indefinitely
    for (int i = 0; i < 20; i++)
      cyc($sformatf("t6solo%0d", i), 4'b0001, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
